mult_pipe_tree: RTL and testbench

- Parametrised, fully pipelined WIDTH x WIDTH integer multiplier.
- Per-transaction signed/unsigned mode.
- Valid/ready handshake on input and output, with global stall for back-pressure.
- Sits in the datapath beside the ALU; the team's next-generation multiplier, one result per cycle at full throughput.

---
 rtl/mult_pkg.sv | 34 +++
 rtl/mult_tree_level.sv | 57 +++++
 rtl/mult_pipe_tree.sv | 129 ++++++++++++
 tb/tb_mult_pipe_tree.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined tree multiplier: clog2 helper, default width, stage sideband.
// Latency: n/a (package only).
// Backpressure: n/a. With MULT_PIPE_TAG_EN defined, the sideband also carries a transaction tag.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 8;

`ifdef MULT_PIPE_TAG_EN
    localparam int MULT_TAG_W_DEFAULT = 4;
    // The sideband tag field is sized for the widest tag supported; the top
    // uses only the low TAG_W bits (TAG_W must not exceed this).
    localparam int MULT_TAG_W_MAX = 16;
`endif

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Per-stage control travelling alongside the data.
    typedef struct packed {
        logic vld;
        logic neg;
`ifdef MULT_PIPE_TAG_EN
        logic [MULT_TAG_W_MAX-1:0] tag;
`endif
    } side_t;

endpackage

// File: rtl/mult_tree_level.sv
// One adder-tree level: registers pairwise sums of TERMS_IN terms; the last level also applies the sign.
// Latency: 1 cycle.
// Backpressure: holds every register while stall is high; data only loads on a valid entry.
//
// Ports: clk, reset (async, active-low), stall, terms_in/side_in (previous level),
//        terms_out/side_out (registered sums and sideband).
module mult_tree_level
    import mult_pkg::*;
#(
    parameter int TERMS_IN = 2,
    parameter int WIDTH    = MULT_WIDTH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 stall,
    input  logic [TERMS_IN-1:0][2*WIDTH-1:0]     terms_in,
    input  side_t                                side_in,
    output logic [TERMS_IN/2-1:0][2*WIDTH-1:0]   terms_out,
    output side_t                                side_out
);

    localparam int  PW   = 2 * WIDTH;
    localparam int  TOUT = TERMS_IN / 2;
    localparam bit  LAST = (TOUT == 1);

    logic [TOUT-1:0][PW-1:0] raw_sum;
    logic [TOUT-1:0][PW-1:0] sum_d;

    always_comb begin
        for (int j = 0; j < TOUT; j++) begin
            raw_sum[j] = terms_in[2*j] + terms_in[2*j+1];
        end
        sum_d = raw_sum;
        // The tree works on magnitudes; the final level restores the sign
        // (two's complement, modulo 2^PW).
        if (LAST && side_in.neg) begin
            sum_d[0] = ~raw_sum[0] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            terms_out <= '0;
            side_out  <= '0;
        end else if (!stall) begin
            // Bubbles only clear valid, so the data (and z at the last level)
            // keep the most recent result.
            if (side_in.vld) begin
                terms_out <= sum_d;
                side_out  <= side_in;
            end else begin
                side_out.vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_pipe_tree.sv
// Fully pipelined WIDTH x WIDTH multiplier (signed/unsigned per transaction): partial products + adder tree.
// Latency: STAGES = clog2(WIDTH)+1 register stages; one result per cycle.
// Backpressure: global stall when out_valid && !out_ready; in_ready = !stall, all stages hold.
//
// Ports: clk, reset (async, active-low), in_valid/in_ready/in_signed/a/b (operand side),
//        out_valid/out_ready/z (result side), busy (any stage valid).
// Optional: define MULT_PIPE_TAG_EN to add TAG_W, in_tag and out_tag (tag travels with its result).
module mult_pipe_tree
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
`ifdef MULT_PIPE_TAG_EN
    ,
    parameter int TAG_W = MULT_TAG_W_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_PIPE_TAG_EN
    input  logic [TAG_W-1:0]   in_tag,
    output logic [TAG_W-1:0]   out_tag,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int STAGES = LEVELS + 1;
    localparam int PW     = 2 * WIDTH;

    logic                    stall;
    logic                    accept;
    logic [WIDTH-1:0]        mag_a;
    logic [WIDTH-1:0]        mag_b;
    logic [WIDTH-1:0][PW-1:0] pp_d;
    logic [WIDTH-1:0][PW-1:0] pp_q;
    side_t                   side0_q;
    side_t                   side [STAGES];

    // Tree nodes in heap order: a level holding T terms occupies [T-1 .. 2T-2];
    // the partial products are the leaves and node[0] is the final result.
    logic [PW-1:0]           node [2*WIDTH-1];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Magnitudes fit in WIDTH unsigned bits, including -2^(W-1) -> 2^(W-1).
    always_comb begin
        mag_a = (in_signed && a[WIDTH-1]) ? -a : a;
        mag_b = (in_signed && b[WIDTH-1]) ? -b : b;
        for (int i = 0; i < WIDTH; i++) begin
            pp_d[i] = mag_b[i] ? ({{WIDTH{1'b0}}, mag_a} << i) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pp_q    <= '0;
            side0_q <= '0;
        end else if (!stall) begin
            if (accept) begin
                pp_q        <= pp_d;
                side0_q.vld <= 1'b1;
                side0_q.neg <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_PIPE_TAG_EN
                side0_q.tag <= MULT_TAG_W_MAX'(in_tag);
`endif
            end else begin
                side0_q.vld <= 1'b0;
            end
        end
    end

    assign side[0] = side0_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign node[WIDTH-1+i] = pp_q[i];
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int TIN  = WIDTH >> (l - 1);
        localparam int TOUT = TIN / 2;

        logic [TIN-1:0][PW-1:0]  lvl_in;
        logic [TOUT-1:0][PW-1:0] lvl_out;

        for (genvar j = 0; j < TIN; j++) begin : g_in
            assign lvl_in[j] = node[TIN-1+j];
        end
        for (genvar j = 0; j < TOUT; j++) begin : g_out
            assign node[TOUT-1+j] = lvl_out[j];
        end

        mult_tree_level #(
            .TERMS_IN (TIN),
            .WIDTH    (WIDTH)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .stall     (stall),
            .terms_in  (lvl_in),
            .side_in   (side[l-1]),
            .terms_out (lvl_out),
            .side_out  (side[l])
        );
    end

    assign z         = node[0];
    assign out_valid = side[LEVELS].vld;
`ifdef MULT_PIPE_TAG_EN
    assign out_tag   = side[LEVELS].tag[TAG_W-1:0];
`endif

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy = busy | side[s].vld;
        end
    end

endmodule

// File: tb/tb_mult_pipe_tree.sv
`timescale 1ns/1ps
module tb_mult_pipe_tree;

    localparam int LAT8 = 3;   // edges after the accept edge until out_valid (STAGES-1, WIDTH=8)
    localparam int LAT4 = 2;   // same for WIDTH=4

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v8, s8, ordy8, rdy8, ov8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;
    logic        v4, s4, ordy4, rdy4, ov4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  z4;
`ifdef MULT_PIPE_TAG_EN
    logic [3:0]  tin8, tout8, tin4, tout4;
`endif

    mult_pipe_tree #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_signed(s8),
        .a(a8), .b(b8),
`ifdef MULT_PIPE_TAG_EN
        .in_tag(tin8), .out_tag(tout8),
`endif
        .out_valid(ov8), .out_ready(ordy8), .z(z8), .busy(busy8)
    );

    mult_pipe_tree #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .in_signed(s4),
        .a(a4), .b(b4),
`ifdef MULT_PIPE_TAG_EN
        .in_tag(tin4), .out_tag(tout4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .z(z4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product of the low w bits of a and b, modulo 2^(2w).
    function automatic logic [15:0] mref(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'(a);
        y = int'(b);
        if (s && a[w-1]) x = x - (1 << w);
        if (s && b[w-1]) y = y - (1 << w);
        p = (x * y) & ((1 << (2 * w)) - 1);
        return p[15:0];
    endfunction

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] z;
    } vec_t;

    vec_t        vt [12];
    logic [15:0] zq [$];
    int          cq [$];
    logic [15:0] ebp [8];
    int          idx, nout, lat, seen;

    task automatic run_one8(input int i);
        @(negedge clk);
        s8 = vt[i].s; a8 = vt[i].a; b8 = vt[i].b; v8 = 1'b1;
        @(negedge clk);
        // Scramble operands and mode after accept; the result must not change.
        v8 = 1'b0; s8 = ~vt[i].s; a8 = 8'h5A; b8 = 8'hC3;
        check($sformatf("busy_v%0d", i), 32'(busy8), 32'd1);
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency_v%0d", i), 32'(lat), 32'(LAT8));
        check($sformatf("z_v%0d", i), 32'(z8), 32'(vt[i].z));
        @(negedge clk);
        check($sformatf("valid_drop_v%0d", i), 32'(ov8), 32'd0);
        check($sformatf("z_hold_v%0d", i), 32'(z8), 32'(vt[i].z));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        v8 = 0; s8 = 0; a8 = 0; b8 = 0; ordy8 = 1;
        v4 = 0; s4 = 0; a4 = 0; b4 = 0; ordy4 = 1;
`ifdef MULT_PIPE_TAG_EN
        tin8 = 0; tin4 = 0;
`endif
        vt[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vt[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vt[2]  = '{1'b1, 8'hFF, 8'h03, 16'hFFFD};
        vt[3]  = '{1'b1, 8'h7F, 8'h81, 16'hC0FF};   // 127 * -127 = -16129
        vt[4]  = '{1'b0, 8'h00, 8'h55, 16'h0000};
        vt[5]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};   // -128 * 127
        vt[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vt[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vt[8]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C};
        vt[9]  = '{1'b1, 8'hF6, 8'h05, 16'hFFCE};   // -10 * 5
        vt[10] = '{1'b0, 8'h80, 8'h7F, 16'h3F80};
        vt[11] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

        // Reset state
        #12;
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_z", 32'(z8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_in_ready", 32'(rdy8), 32'd1);
`ifdef MULT_PIPE_TAG_EN
        check("rst_out_tag", 32'(tout8), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Single transactions, both modes
        for (int i = 0; i < 12; i++) run_one8(i);

        // Back-to-back pairs (k, k+1)
        zq.delete(); cq.delete();
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    @(negedge clk);
                    v8 = 1'b1; s8 = 1'b0; a8 = 8'(k); b8 = 8'(k + 1);
                end
                @(negedge clk);
                v8 = 1'b0;
            end
            begin
                for (int c = 0; c < 30 && zq.size() < 6; c++) begin
                    @(negedge clk);
                    if (ov8) begin
                        zq.push_back(z8);
                        cq.push_back(c);
                    end
                end
            end
        join
        check("b2b_count", 32'(zq.size()), 32'd6);
        for (int j = 0; j < zq.size(); j++) begin
            check($sformatf("b2b_z%0d", j), 32'(zq[j]), 32'((j + 1) * (j + 2)));
            check($sformatf("b2b_cycle%0d", j), 32'(cq[j] - cq[0]), 32'(j));
        end
        repeat (5) @(negedge clk);

        // Back-pressure: fill, stall 5 cycles, drain
        for (int k = 0; k < 8; k++)
            ebp[k] = mref(8, k[0], 8'(8'hF3 - 8'(k * 17)), 8'(k * 29 + 5));
        idx = 0; nout = 0;
        for (int c = 0; c < 80 && nout < 8; c++) begin
            @(negedge clk);
            ordy8 = (c >= 9);
            v8 = (idx < 8);
            if (idx < 8) begin
                s8 = idx[0]; a8 = 8'(8'hF3 - 8'(idx * 17)); b8 = 8'(idx * 29 + 5);
            end
            #1;
            if (c >= 4 && c <= 8) begin
                check($sformatf("bp_in_ready_c%0d", c), 32'(rdy8), 32'd0);
                check($sformatf("bp_out_valid_c%0d", c), 32'(ov8), 32'd1);
                check($sformatf("bp_z_frozen_c%0d", c), 32'(z8), 32'(ebp[0]));
            end
            if (c == 8) check("bp_no_accept_in_stall", 32'(idx), 32'd4);
            if (ov8 && ordy8) begin
                check($sformatf("bp_result%0d", nout), 32'(z8), 32'(ebp[nout]));
                nout++;
            end
            if (v8 && rdy8) idx++;
        end
        check("bp_result_count", 32'(nout), 32'd8);
        @(negedge clk);
        v8 = 1'b0; ordy8 = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_drained_valid", 32'(ov8), 32'd0);
        check("bp_drained_busy", 32'(busy8), 32'd0);

        // Reset with three entries in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v8 = 1'b1; s8 = 1'b1; a8 = 8'(8'h85 + k); b8 = 8'h3C;
        end
        @(posedge clk);
        #3;
        v8 = 1'b0;
        check("inflight_busy", 32'(busy8), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(ov8), 32'd0);
        check("arst_z", 32'(z8), 32'd0);
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_in_ready", 32'(rdy8), 32'd1);
        #3;
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        check("arst_no_stale_valid", 32'(seen), 32'd0);
        check("arst_z_stays_zero", 32'(z8), 32'd0);

        // WIDTH=4: single transaction with tag
        @(negedge clk);
        v4 = 1'b1; s4 = 1'b0; a4 = 4'd9; b4 = 4'd7;
`ifdef MULT_PIPE_TAG_EN
        tin4 = 4'hA;
`endif
        @(negedge clk);
        v4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
`ifdef MULT_PIPE_TAG_EN
        tin4 = 4'h0;
`endif
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w4_latency", 32'(lat), 32'(LAT4));
        check("w4_z", 32'(z4), 32'h3F);
`ifdef MULT_PIPE_TAG_EN
        check("w4_out_tag", 32'(tout4), 32'hA);
`endif
        @(negedge clk);

        // WIDTH=4: exhaustive, both modes, streamed back-to-back
        idx = 0; nout = 0;
        for (int c = 0; c < 1200 && nout < 512; c++) begin
            @(negedge clk);
            v4 = (idx < 512);
            if (idx < 512) begin
                s4 = idx[8]; a4 = idx[7:4]; b4 = idx[3:0];
`ifdef MULT_PIPE_TAG_EN
                tin4 = idx[7:4] ^ idx[3:0];
`endif
            end
            #1;
            if (ov4) begin
                check($sformatf("w4_exh_%0d", nout), 32'(z4),
                      32'(mref(4, nout[8], {4'b0, nout[7:4]}, {4'b0, nout[3:0]})));
`ifdef MULT_PIPE_TAG_EN
                check($sformatf("w4_tag_%0d", nout), 32'(tout4), 32'(nout[7:4] ^ nout[3:0]));
`endif
                nout++;
            end
            if (v4 && rdy4) idx++;
        end
        check("w4_exh_count", 32'(nout), 32'd512);
        @(negedge clk);
        v4 = 1'b0;
        repeat (4) @(negedge clk);
        check("w4_idle_busy", 32'(busy4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
